// File: rtl/fir_out_requant_pkg.sv
// Shared FIR definitions: output width, requantiser defaults and FSM states.
package fir_out_requant_pkg;

    localparam int YOUT_W     = 24;
    localparam int DEF_DOUT_W = 16;
    localparam int DEF_SHIFT  = 8;
    localparam int DEF_DECIM  = 2;
    localparam int DEF_WARMUP = 8;

    typedef enum logic {
        WARM,
        RUN
    } fsm_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head is visible whenever not empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp;
    logic [AW:0]      rp;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit tells a full buffer from an empty one.
    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push)
                wp <= wp + {{AW{1'b0}}, 1'b1};
            if (do_pop)
                rp <= rp + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wp[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fir_out_requant.sv
// FIR output requantiser: warm-up discard, decimation, round, saturate, buffer.
module fir_out_requant
    import fir_out_requant_pkg::*;
#(
    parameter int YIN_W      = YOUT_W,
    parameter int DOUT_W     = DEF_DOUT_W,
    parameter int SHIFT      = DEF_SHIFT,
    parameter int DECIM      = DEF_DECIM,
    parameter int WARMUP     = DEF_WARMUP,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [YIN_W-1:0]  yin,
    input  logic              yin_en,
    output logic [DOUT_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [15:0]       sat_cnt,
    output logic [15:0]       drop_cnt
);
    localparam int RW = YIN_W + 1;
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int CW = $clog2(WARMUP + 1) + 1;

    localparam logic signed [RW-1:0] HALF = RW'((2 ** SHIFT) / 2);
    localparam logic signed [RW-1:0] MAXV =
        RW'((longint'(1) <<< (DOUT_W - 1)) - 1);
    localparam logic signed [RW-1:0] MINV = ~MAXV;

    localparam logic [CW-1:0] LAST_WARM = CW'(WARMUP - 1);
    localparam logic [PW-1:0] LAST_PH   = PW'(DECIM - 1);
    localparam fsm_state_t    INIT      = (WARMUP == 0) ? RUN : WARM;

    fsm_state_t state;
    fsm_state_t state_nx;
    logic [CW-1:0] warm_cnt;
    logic [PW-1:0] phase;
    logic keep;

    logic signed [RW-1:0] ext;
    logic signed [RW-1:0] s1_r;
    logic                 s1_valid;
    logic [DOUT_W-1:0]    s2_data;
    logic                 s2_valid;
    logic [DOUT_W-1:0]    clip;
    logic                 clipped;

    logic full;
    logic empty;
    logic drop;

    always_ff @(posedge clk) begin
        if (rst)
            state <= INIT;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        keep     = 1'b0;
        unique case (state)
            WARM: begin
                if (yin_en && warm_cnt == LAST_WARM)
                    state_nx = RUN;
            end
            RUN: keep = yin_en && (phase == '0);
            default: state_nx = INIT;
        endcase
    end

    assign ext = $signed({yin[YIN_W-1], yin});

    always_comb begin
        clip    = s1_r[DOUT_W-1:0];
        clipped = 1'b0;
        if (s1_r > MAXV) begin
            clip    = MAXV[DOUT_W-1:0];
            clipped = 1'b1;
        end else if (s1_r < MINV) begin
            clip    = MINV[DOUT_W-1:0];
            clipped = 1'b1;
        end
    end

    // A full FIFO still accepts the write when the consumer pops the same cycle.
    assign drop = s2_valid && full && !m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            warm_cnt <= '0;
            phase    <= '0;
            s1_valid <= 1'b0;
            s1_r     <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            sat_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (state == WARM && yin_en)
                warm_cnt <= warm_cnt + 1'b1;
            if (state == RUN && yin_en)
                phase <= (phase == LAST_PH) ? '0 : phase + 1'b1;
            s1_valid <= keep;
            s1_r     <= (ext + HALF) >>> SHIFT;
            s2_valid <= s1_valid;
            s2_data  <= clip;
            if (s1_valid && clipped)
                sat_cnt <= sat_inc(sat_cnt);
            if (drop)
                drop_cnt <= sat_inc(drop_cnt);
        end
    end

    sync_fifo_fwft #(
        .WIDTH (DOUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s2_valid),
        .push_data (s2_data),
        .pop       (m_ready),
        .head      (m_data),
        .full      (full),
        .empty     (empty)
    );

    assign m_valid = !empty;

endmodule

// File: tb/tb_fir_out_requant.sv
// Scoreboard bench: two requantiser configurations against a reference model.
module tb_fir_out_requant;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      [2];
    logic [23:0] yin      [2];
    logic        yin_en   [2];
    logic        m_ready  [2];
    logic [15:0] m_data   [2];
    logic        m_valid  [2];
    logic [15:0] sat_cnt  [2];
    logic [15:0] drop_cnt [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int exp0 [$];
    int exp1 [$];
    int n_acc [2];
    int wu [2];
    int dc [2];
    int esat [2];
    int edrop [2];
    int npop [2];
    int first_valid [2];

    always @(posedge clk) cyc <= cyc + 1;

    fir_out_requant #(
        .YIN_W(24), .DOUT_W(16), .SHIFT(8),
        .DECIM(2), .WARMUP(4), .FIFO_DEPTH(4)
    ) dut0 (
        .clk(clk), .rst(rst[0]), .yin(yin[0]), .yin_en(yin_en[0]),
        .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
        .sat_cnt(sat_cnt[0]), .drop_cnt(drop_cnt[0])
    );

    fir_out_requant #(
        .YIN_W(24), .DOUT_W(16), .SHIFT(8),
        .DECIM(1), .WARMUP(0), .FIFO_DEPTH(4)
    ) dut1 (
        .clk(clk), .rst(rst[1]), .yin(yin[1]), .yin_en(yin_en[1]),
        .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
        .sat_cnt(sat_cnt[1]), .drop_cnt(drop_cnt[1])
    );

    function automatic int qsize(int i);
        return (i == 0) ? exp0.size() : exp1.size();
    endfunction

    function automatic void qpush(int i, int v);
        if (i == 0) exp0.push_back(v);
        else exp1.push_back(v);
    endfunction

    function automatic int qpop(int i);
        return (i == 0) ? exp0.pop_front() : exp1.pop_front();
    endfunction

    // Reference: round half up to 1/256 steps, then clamp to 16-bit signed.
    function automatic int requant(logic [23:0] y, output bit sat);
        longint v;
        longint r;
        v   = longint'($signed(y)) + 128;
        r   = (v >= 0) ? v / 256 : -((-v + 255) / 256);
        sat = 1'b0;
        if (r > 32767) begin
            r   = 32767;
            sat = 1'b1;
        end else if (r < -32768) begin
            r   = -32768;
            sat = 1'b1;
        end
        return int'(r);
    endfunction

    function automatic bit would_keep(int i);
        return n_acc[i] >= wu[i] && ((n_acc[i] - wu[i]) % dc[i]) == 0;
    endfunction

    task automatic check(string name, int act, int want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic clear_model(int i);
        if (i == 0) exp0.delete();
        else exp1.delete();
        n_acc[i]       = 0;
        esat[i]        = 0;
        edrop[i]       = 0;
        npop[i]        = 0;
        first_valid[i] = -1;
    endtask

    // Present one cycle of input; the model decides keep/drop when issued.
    task automatic step(int i, logic [23:0] y, bit en, bit force_push = 1'b0);
        yin[i]    = y;
        yin_en[i] = en;
        if (en) begin
            bit keep;
            bit s;
            int v;
            keep = would_keep(i);
            n_acc[i]++;
            if (keep) begin
                v = requant(y, s);
                if (s) esat[i]++;
                if (force_push || qsize(i) < 4) qpush(i, v);
                else edrop[i]++;
            end
        end
        @(posedge clk);
        #1;
        yin_en[i] = 1'b0;
    endtask

    task automatic idle(int i, int n);
        repeat (n) step(i, 24'd0, 1'b0);
    endtask

    task automatic drain(int i, string name);
        int k;
        k = 0;
        m_ready[i] = 1'b1;
        while (qsize(i) > 0 && k < 40) begin
            step(i, 24'd0, 1'b0);
            k++;
        end
        if (qsize(i) > 0) begin
            tests++;
            fails++;
            $display("FAIL %s_drain: %0d outputs missing after timeout", name, qsize(i));
        end
        idle(i, 2);
        check({name, "_valid_low"}, int'(m_valid[i]), 0);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst[i] && m_valid[i] && first_valid[i] < 0)
                first_valid[i] = cyc;
            if (!rst[i] && m_valid[i] && m_ready[i]) begin
                npop[i]++;
                if (qsize(i) == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL out%0d_extra: got %0d, expected no output",
                             i, $signed(m_data[i]));
                end else begin
                    check($sformatf("out%0d_data", i),
                          int'($signed(m_data[i])), qpop(i));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rec;
        int np;
        logic [23:0] y;
        bit en;
        wu[0] = 4;
        dc[0] = 2;
        wu[1] = 0;
        dc[1] = 1;
        for (int i = 0; i < 2; i++) begin
            rst[i]     = 1'b1;
            yin[i]     = '0;
            yin_en[i]  = 1'b0;
            m_ready[i] = 1'b0;
            clear_model(i);
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst%0d_valid", i), int'(m_valid[i]), 0);
            check($sformatf("rst%0d_data", i), int'(m_data[i]), 0);
            check($sformatf("rst%0d_sat", i), int'(sat_cnt[i]), 0);
            check($sformatf("rst%0d_drop", i), int'(drop_cnt[i]), 0);
        end

        m_ready[1] = 1'b1;
        step(1, 24'd384, 1'b1);
        step(1, -24'sd384, 1'b1);
        step(1, 24'd383, 1'b1);
        drain(1, "round");
        check("round_sat", int'(sat_cnt[1]), 0);

        step(1, 24'h7FFFFF, 1'b1);
        step(1, 24'h800000, 1'b1);
        drain(1, "sat");
        check("sat_cnt", int'(sat_cnt[1]), esat[1]);
        check("sat_cnt_one", int'(sat_cnt[1]), 1);

        m_ready[1] = 1'b0;
        for (int k = 1; k <= 6; k++) step(1, 24'(k * 1000), 1'b1);
        idle(1, 4);
        check("bp_drop", int'(drop_cnt[1]), edrop[1]);
        check("bp_drop_two", int'(drop_cnt[1]), 2);
        check("bp_valid", int'(m_valid[1]), 1);
        drain(1, "bp");

        m_ready[1] = 1'b0;
        for (int k = 1; k <= 4; k++) step(1, 24'(k * 700), 1'b1);
        idle(1, 4);
        step(1, 24'd5555, 1'b1, 1'b1);
        step(1, 24'd0, 1'b0);
        m_ready[1] = 1'b1;
        step(1, 24'd0, 1'b0);
        m_ready[1] = 1'b0;
        idle(1, 2);
        check("rw_full_drop", int'(drop_cnt[1]), 2);
        check("rw_full_valid", int'(m_valid[1]), 1);
        np = npop[1];
        drain(1, "rw_full");
        check("rw_full_occ", npop[1] - np, 4);

        m_ready[0] = 1'b1;
        rec = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 5) rec = cyc;
            step(0, 24'(k * 256), 1'b1);
        end
        drain(0, "warm");
        check("warm_latency", first_valid[0] - rec, 3);
        check("warm_count", npop[0], 4);

        m_ready[0] = 1'b0;
        for (int k = 1; k <= 9; k++)
            step(0, (k == 7) ? 24'h7FFFFF : 24'(k * 300), 1'b1);
        idle(0, 4);
        check("mid_valid", int'(m_valid[0]), 1);
        check("mid_sat", int'(sat_cnt[0]), 1);
        rst[0] = 1'b1;
        step(0, 24'd0, 1'b0);
        check("mid_rst_valid", int'(m_valid[0]), 0);
        check("mid_rst_sat", int'(sat_cnt[0]), 0);
        check("mid_rst_drop", int'(drop_cnt[0]), 0);
        clear_model(0);
        rst[0] = 1'b0;
        m_ready[0] = 1'b1;
        for (int k = 1; k <= 8; k++) step(0, 24'(k * 512), 1'b1);
        drain(0, "rewarm");
        check("rewarm_count", npop[0], 2);

        for (int t = 0; t < 400; t++) begin
            m_ready[0] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0)
                y = 24'($urandom());
            else
                y = 24'(int'($urandom_range(0, 80000)) - 40000);
            en = 1'($urandom_range(0, 1));
            if (en && would_keep(0) && qsize(0) >= 4) en = 1'b0;
            step(0, y, en);
        end
        drain(0, "rand");
        check("rand_sat", int'(sat_cnt[0]), esat[0]);
        check("rand_drop", int'(drop_cnt[0]), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
